// File: rtl/ram_if_pkg.sv
// Shared constants and types for the RAM read-side master.
// The halfword packing matches the RAM's 32-bit strobed write port.
package ram_if_pkg;

  localparam int ADDR_W = 4;
  localparam int HW_W   = 16;

  localparam logic [1:0] STRB_FULL = 2'b11;
  localparam logic [1:0] STRB_LO   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry synchronous FIFO with occupancy count and same-cycle push/pop.
// Storage is not reset; only pointers and count are.
module word_fifo2 #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push_ok) r_wptr <= ~r_wptr;
      if (w_pop_ok)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/dual_port_ram_reader.sv
// Burst read master for the dual-port RAM: issues halfword reads, packs pairs
// into 32-bit strobed words and streams them out on a valid/ready interface.
module dual_port_ram_reader
  import ram_if_pkg::*;
#(
  parameter int ADDR_W = ram_if_pkg::ADDR_W,
  parameter int HW_W   = ram_if_pkg::HW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W:0]   req_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] raddr,
  input  logic [HW_W-1:0]   rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2*HW_W-1:0] m_data,
  output logic [1:0]        m_strb,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = 2 * HW_W;
  localparam int ENTRY_W = WORD_W + 3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_rem;
  logic                r_par_issue;
  logic [1:0]          r_open;
  logic                r_done;

  logic                r_vld_p1;
  logic                r_odd_p1;
  logic                r_fin_p1;
  logic [HW_W-1:0]     r_lo_p2;

  logic                w_req_hs;
  logic                w_credit_ok;
  logic                w_final_issue;
  logic                w_open_inc;
  logic                w_push;
  logic                w_pop;
  logic [2:0]          w_occ;
  logic [1:0]          w_cnt;
  logic [ENTRY_W-1:0]  w_push_entry;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_head_last;
  logic [1:0]          w_head_strb;
  logic [WORD_W-1:0]   w_head_data;
  logic [WORD_W-1:0]   w_push_data;
  logic [1:0]          w_push_strb;

  assign w_req_hs      = req_ready && req_valid;
  assign w_pop         = m_valid && m_ready;
  assign w_final_issue = rd_en && (r_rem == {{ADDR_W{1'b0}}, 1'b1});
  assign w_open_inc    = rd_en && !r_par_issue;

  // Only a word-opening (even) read needs a free slot; its odd partner
  // completes a word that already holds one.
  assign w_occ       = {1'b0, w_cnt} + {1'b0, r_open};
  assign w_credit_ok = r_par_issue || (w_occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_hs && (req_len != '0)) w_state_nxt = ST_READ;
      ST_READ:  if (w_final_issue) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    rd_en     = (r_state == ST_READ) && w_credit_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_par_issue <= 1'b0;
    end else if (w_req_hs) begin
      r_addr      <= req_addr;
      r_rem       <= req_len;
      r_par_issue <= 1'b0;
    end else if (rd_en) begin
      r_addr      <= r_addr + 1'b1;
      r_rem       <= r_rem - 1'b1;
      r_par_issue <= ~r_par_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_open <= 2'd0;
      r_done <= 1'b0;
    end else begin
      case ({w_open_inc, w_push})
        2'b10:   r_open <= r_open + 2'd1;
        2'b01:   r_open <= r_open - 2'd1;
        default: r_open <= r_open;
      endcase
      r_done <= (w_req_hs && (req_len == '0)) ||
                ((r_state == ST_DRAIN) && w_pop && w_head_last);
    end
  end

  // p1: read in flight, rdata valid this cycle
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= rd_en;
    r_odd_p1 <= r_par_issue;
    r_fin_p1 <= w_final_issue;
  end

  // p2: low halfword held until its partner arrives
  always_ff @(posedge clk) begin
    if (r_vld_p1 && !r_odd_p1) r_lo_p2 <= rdata;
  end

  assign w_push       = r_vld_p1 && (r_odd_p1 || r_fin_p1);
  assign w_push_data  = r_odd_p1 ? {rdata, r_lo_p2} : {{HW_W{1'b0}}, rdata};
  assign w_push_strb  = r_odd_p1 ? STRB_FULL : STRB_LO;
  assign w_push_entry = {r_fin_p1, w_push_strb, w_push_data};

  word_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_cnt)
  );

  assign w_head_last = w_head[ENTRY_W-1];
  assign w_head_strb = w_head[ENTRY_W-2 -: 2];
  assign w_head_data = w_head[WORD_W-1:0];

  assign m_valid = (w_cnt != 2'd0);
  assign m_data  = m_valid ? w_head_data : '0;
  assign m_strb  = m_valid ? w_head_strb : 2'b00;
  assign m_last  = m_valid && w_head_last;
  assign raddr   = r_addr;
  assign done    = r_done;

endmodule

// File: tb/tb_dual_port_ram_reader.sv
// Directed bench for dual_port_ram_reader against a behavioural 16x16 RAM.
module tb_dual_port_ram_reader;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [4:0]  req_len;
  logic        rd_en;
  logic [3:0]  raddr;
  logic [15:0] rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  m_strb;
  logic        m_last;
  logic        busy;
  logic        done;

  dual_port_ram_reader #(.ADDR_W(4), .HW_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_strb    (m_strb),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [16];
  always @(posedge clk) rdata <= rd_en ? mem[raddr] : 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor state
  int          rd_cnt, first_rd, first_vld, last_hs, done_cnt, done_cyc;
  logic [3:0]  raddr_q [$];
  logic [31:0] bd_q [$];
  logic [1:0]  bs_q [$];
  logic        bl_q [$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [1:0]  prev_s;
  logic        prev_l;
  int          c0;

  task automatic clear_mon();
    rd_cnt = 0; first_rd = -1; first_vld = -1; last_hs = -100;
    done_cnt = 0; done_cyc = -100;
    raddr_q.delete(); bd_q.delete(); bs_q.delete(); bl_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_d);
        chk("stall_strb", {30'd0, m_strb}, {30'd0, prev_s});
        chk("stall_last", {31'd0, m_last}, {31'd0, prev_l});
      end
      if (rd_en) begin
        rd_cnt++;
        raddr_q.push_back(raddr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (m_valid && m_ready) begin
        bd_q.push_back(m_data);
        bs_q.push_back(m_strb);
        bl_q.push_back(m_last);
        if (m_last) last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_d = m_data; prev_s = m_strb; prev_l = m_last;
  end

  function automatic logic [31:0] exp_data(input logic [3:0] a, input int l, input int k);
    logic [15:0] lo, hi;
    lo = 16'hA000 + 16'((int'(a) + 2*k) % 16);
    hi = (2*k + 1 < l) ? 16'hA000 + 16'((int'(a) + 2*k + 1) % 16) : 16'h0000;
    return {hi, lo};
  endfunction

  // Caller sits just after a rising edge; returns just after the accept edge.
  task automatic send_req(input logic [3:0] a, input logic [4:0] l);
    logic rdy;
    logic ok;
    clear_mon();
    req_addr = a; req_len = l; req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        c0 = cyc;
      end
    end
    if (!ok) chk("req_accept", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == 0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_beats(input string nm, input logic [3:0] a, input int l);
    int nw;
    nw = (l + 1) / 2;
    chk({nm, "_nbeats"}, bd_q.size(), nw);
    for (int k = 0; k < bd_q.size() && k < nw; k++) begin
      chk({nm, "_data"}, bd_q[k], exp_data(a, l, k));
      chk({nm, "_strb"}, {30'd0, bs_q[k]},
          ((l % 2 == 1) && (k == nw - 1)) ? 32'd1 : 32'd3);
      chk({nm, "_last"}, {31'd0, bl_q[k]}, (k == nw - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_rd_en"},     {31'd0, rd_en},     32'd0);
    chk({nm, "_raddr"},     {28'd0, raddr},     32'd0);
    chk({nm, "_m_valid"},   {31'd0, m_valid},   32'd0);
    chk({nm, "_m_data"},    m_data,             32'd0);
    chk({nm, "_m_strb"},    {30'd0, m_strb},    32'd0);
    chk({nm, "_m_last"},    {31'd0, m_last},    32'd0);
    chk({nm, "_busy"},      {31'd0, busy},      32'd0);
    chk({nm, "_done"},      {31'd0, done},      32'd0);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [4:0]  len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] wl;
    logic [1:0]  sl;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{4'd2,  5'd4,  2, 32'hA003A002, 32'hA005A004, 2'b11};
    vecs[1] = '{4'd14, 5'd3,  2, 32'hA00FA00E, 32'h0000A000, 2'b01};
    vecs[2] = '{4'd0,  5'd1,  1, 32'h0000A000, 32'h0000A000, 2'b01};
    vecs[3] = '{4'd9,  5'd16, 8, 32'hA00AA009, 32'hA008A007, 2'b11};
    vecs[4] = '{4'd15, 5'd2,  1, 32'hA000A00F, 32'hA000A00F, 2'b11};
    vecs[5] = '{4'd5,  5'd5,  3, 32'hA006A005, 32'h0000A009, 2'b01};

    for (int k = 0; k < 16; k++) mem[k] = 16'hA000 + 16'(k);
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; m_ready = 1'b1;
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    // Table-driven bursts with the sink always ready
    for (int v = 0; v < 6; v++) begin
      m_ready = 1'b1;
      send_req(vecs[v].addr, vecs[v].len);
      wait_done(100);
      chk("vec_nwords", bd_q.size(), vecs[v].nw);
      if (bd_q.size() > 0) begin
        chk("vec_first_word", bd_q[0], vecs[v].w0);
        chk("vec_last_word", bd_q[bd_q.size()-1], vecs[v].wl);
        chk("vec_last_strb", {30'd0, bs_q[bs_q.size()-1]}, {30'd0, vecs[v].sl});
      end
      check_beats("vec", vecs[v].addr, int'(vecs[v].len));
      chk("vec_rd_count", rd_cnt, int'(vecs[v].len));
      for (int i = 0; i < raddr_q.size(); i++)
        chk("vec_raddr", {28'd0, raddr_q[i]}, (int'(vecs[v].addr) + i) % 16);
      chk("vec_first_rd", first_rd, c0);
      if (vecs[v].len >= 2) chk("vec_first_valid", first_vld, c0 + 3);
      chk("vec_done_after_last", done_cyc, last_hs + 1);
      chk("vec_done_count", done_cnt, 1);
      chk("vec_idle_busy", {31'd0, busy}, 32'd0);
      chk("vec_idle_ready", {31'd0, req_ready}, 32'd1);
    end

    // Empty burst
    send_req(4'd3, 5'd0);
    repeat (6) begin @(posedge clk); #1; end
    chk("len0_rd_count", rd_cnt, 0);
    chk("len0_valid_seen", first_vld, -1);
    chk("len0_done_count", done_cnt, 1);
    chk("len0_done_cycle", done_cyc, c0);

    // Backpressure: sink stalled for 10 cycles after accept
    m_ready = 1'b0;
    send_req(4'd0, 5'd16);
    repeat (10) begin @(posedge clk); #1; end
    chk("bp_rd_count", rd_cnt, 4);
    chk("bp_rd_en_low", {31'd0, rd_en}, 32'd0);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_head_data", m_data, 32'hA001A000);
    m_ready = 1'b1;
    wait_done(200);
    check_beats("bp", 4'd0, 16);
    chk("bp_rd_total", rd_cnt, 16);
    chk("bp_done_count", done_cnt, 1);

    // Reset in the middle of a read burst
    m_ready = 1'b1;
    send_req(4'd0, 5'd8);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    clear_mon();
    repeat (6) begin @(posedge clk); #1; end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_beats", bd_q.size(), 0);
    chk("rst_no_reads", rd_cnt, 0);
    send_req(4'd4, 5'd2);
    wait_done(100);
    check_beats("post_rst", 4'd4, 2);
    if (bd_q.size() > 0) chk("post_rst_word", bd_q[0], 32'hA005A004);
    chk("post_rst_done", done_cnt, 1);

    // Sink ready toggling every cycle over an odd burst
    m_ready = 1'b0;
    send_req(4'd10, 5'd7);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_done(20);
    check_beats("toggle", 4'd10, 7);
    if (bd_q.size() == 4) begin
      chk("toggle_w0", bd_q[0], 32'hA00BA00A);
      chk("toggle_w3", bd_q[3], 32'h0000A000);
      chk("toggle_strb3", {30'd0, bs_q[3]}, 32'd1);
    end
    chk("toggle_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
